bcc: RTL and testbench



---
 rtl/bcc.sv | 79 +++++++
 tb/tb_bcc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bcc.sv
// -----------------------------------------------------------------------------
// bcc -- branch condition check unit
//
// Evaluates a 4-bit ARM condition code against the current ALU flags and
// registers the result as the execute/take-branch qualifier Ok (1-cycle
// latency). Holds no state other than the output register.
//
// Ports:
//   clk          in  1  system clock, rising-edge active
//   rst          in  1  synchronous, active-high reset (Ok -> 0)
//   flags        in  4  condition flags packed [Z, C, N, V]
//   branch_cond  in  4  ARM condition field (instr[31:28])
//   Ok           out 1  registered "condition satisfied"
//
// Configuration:
//   BCC_NV_ALWAYS_EN  undefined (default): cond 1111 (NV) evaluates to 0.
//                     defined: cond 1111 evaluates to 1 (ARMv5+ unconditional
//                     extension space). No other encoding is affected.
// -----------------------------------------------------------------------------
module bcc (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] flags,
  input  logic [3:0] branch_cond,
  output logic       Ok
);

  logic z_s;
  logic c_s;
  logic n_s;
  logic v_s;
  logic pass_s;
  logic ok_r;

  assign z_s = flags[3];
  assign c_s = flags[2];
  assign n_s = flags[1];
  assign v_s = flags[0];

  // Condition decode: full case, each encoding looks only at the flags it names.
  always_comb begin
    pass_s = 1'b0;
    case (branch_cond)
      4'b0000: pass_s = z_s;                        // EQ
      4'b0001: pass_s = ~z_s;                       // NE
      4'b0010: pass_s = c_s;                        // CS/HS
      4'b0011: pass_s = ~c_s;                       // CC/LO
      4'b0100: pass_s = n_s;                        // MI
      4'b0101: pass_s = ~n_s;                       // PL
      4'b0110: pass_s = v_s;                        // VS
      4'b0111: pass_s = ~v_s;                       // VC
      4'b1000: pass_s = c_s & ~z_s;                 // HI
      4'b1001: pass_s = ~c_s | z_s;                 // LS
      4'b1010: pass_s = ~(n_s ^ v_s);               // GE
      4'b1011: pass_s = n_s ^ v_s;                  // LT
      4'b1100: pass_s = ~z_s & ~(n_s ^ v_s);        // GT
      4'b1101: pass_s = z_s | (n_s ^ v_s);          // LE
      4'b1110: pass_s = 1'b1;                       // AL
`ifdef BCC_NV_ALWAYS_EN
      4'b1111: pass_s = 1'b1;                       // NV space treated as unconditional
`else
      4'b1111: pass_s = 1'b0;                       // NV: never execute
`endif
      default: pass_s = 1'b0;
    endcase
  end

  // Output register: reset has priority and discards the pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_r <= 1'b0;
    end else begin
      ok_r <= pass_s;
    end
  end

  assign Ok = ok_r;

endmodule

// File: tb/tb_bcc.sv
// -----------------------------------------------------------------------------
// tb_bcc -- self-checking bench for bcc.
// A behavioural model predicts Ok one cycle after the inputs are sampled; a
// compare process checks every cycle on the falling edge. Directed checks with
// hand-computed literals pin the model to the condition table.
// -----------------------------------------------------------------------------
module tb_bcc;

  logic       clk;
  logic       rst;
  logic [3:0] flags;
  logic [3:0] branch_cond;
  logic       Ok;

  int total;
  int bad;

  logic exp_q;
  logic exp_v;

`ifdef BCC_NV_ALWAYS_EN
  localparam logic NV_VAL = 1'b1;
`else
  localparam logic NV_VAL = 1'b0;
`endif

  bcc dut (
    .clk         (clk),
    .rst         (rst),
    .flags       (flags),
    .branch_cond (branch_cond),
    .Ok          (Ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM-style model: odd encodings are the negation of the preceding even one.
  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    bit z, cy, n, v, base;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return NV_VAL;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b0;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Expected output register, one cycle behind the inputs.
  always @(posedge clk) begin
    exp_q <= rst ? 1'b0 : model(branch_cond, flags);
    exp_v <= 1'b1;
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (exp_v === 1'b1) begin
      total++;
      if (Ok !== exp_q) begin
        bad++;
        $display("FAIL model_cmp t=%0t cond=%b flags=%b rst=%b Ok=%b expected=%b",
                 $time, branch_cond, flags, rst, Ok, exp_q);
      end
    end
  end

  task automatic lit(input string name, input logic want);
    total++;
    if (Ok !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, Ok, want);
    end
  endtask

  // Apply inputs after a falling edge, then sample after the next one.
  task automatic step(input logic r, input logic [3:0] f, input logic [3:0] c);
    rst = r; flags = f; branch_cond = c;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    exp_v = 1'b0; exp_q = 1'b0;
    rst = 1'b1; flags = 4'b0000; branch_cond = 4'b1110;
    @(negedge clk);

    // Reset holds Ok low even with AL, release gives 1 one cycle later.
    step(1'b1, 4'b0000, 4'b1110); lit("reset_hold", 1'b0);
    step(1'b0, 4'b0000, 4'b1110); lit("reset_release", 1'b1);

    // EQ/NE
    step(1'b0, 4'b1111, 4'b0000); lit("eq_z1", 1'b1);
    step(1'b0, 4'b0110, 4'b0000); lit("eq_z0", 1'b0);
    step(1'b0, 4'b0111, 4'b0001); lit("ne_z0", 1'b1);
    // Carry/sign
    step(1'b0, 4'b0010, 4'b0010); lit("cs", 1'b0);
    step(1'b0, 4'b1101, 4'b0011); lit("cc", 1'b0);
    step(1'b0, 4'b0110, 4'b0100); lit("mi", 1'b1);
    step(1'b0, 4'b0000, 4'b0101); lit("pl", 1'b1);
    // Signed/compound
    step(1'b0, 4'b0011, 4'b1010); lit("ge", 1'b1);
    step(1'b0, 4'b0011, 4'b1011); lit("lt", 1'b0);
    step(1'b0, 4'b1011, 4'b1100); lit("gt", 1'b0);
    step(1'b0, 4'b0101, 4'b1000); lit("hi", 1'b1);
    step(1'b0, 4'b0100, 4'b1001); lit("ls", 1'b0);
    step(1'b0, 4'b1001, 4'b1101); lit("le", 1'b1);
    step(1'b0, 4'b0000, 4'b1111); lit("nv", NV_VAL);

    // Reset mid-stream with AL: exactly one low cycle.
    step(1'b0, 4'b0000, 4'b1110); lit("mid_pre", 1'b1);
    step(1'b1, 4'b0000, 4'b1110); lit("mid_rst", 1'b0);
    step(1'b0, 4'b0000, 4'b1110); lit("mid_post", 1'b1);

    // Exhaustive sweep (model compare process checks each cycle).
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        step(1'b0, 4'(f), 4'(c));
      end
    end

    // Randomized stimulus with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
